// File: rtl/usb_cmd_decoder_multi_if.sv
// rtl/usb_cmd_decoder_multi_if.sv - control-word valid/ready handshake bundle
interface usb_cmd_decoder_multi_if #(
  parameter int CMD_W = 16
);
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/usb_cmd_decoder_multi.sv
// rtl/usb_cmd_decoder_multi.sv - buffered USB control-word decoder for the DAQ card
module usb_cmd_decoder_multi #(
  parameter int CMD_W      = 16,
  parameter int N_CH       = 4,
  parameter int AVG_W      = 3,
  parameter int LED_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_PULSE  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  usb_cmd_decoder_multi_if.slave cmd,
  output logic [N_CH-1:0]      ch_enable,
  output logic [AVG_W-1:0]     avg_points,
  output logic [LED_W-1:0]     led,
  output logic                 fifo_rst,
  output logic [15:0]          cmd_count,
  output logic [7:0]           err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(RST_PULSE + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, exec_en;
  logic [CMD_W-1:0] cmd_reg;
  logic [PW-1:0]    pulse_cnt;

  logic [7:0]       opcode, nn;
  logic             nn_ok, is_err, is_clr, is_pulse;
  logic [N_CH-1:0]  ch_d;
  logic [AVG_W-1:0] avg_d;
  logic [LED_W-1:0] led_d;

  // Ready comes straight from registered occupancy so it never depends on cmd_valid.
  assign cmd.cmd_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign fifo_rst      = (pulse_cnt != '0);
  assign opcode        = cmd_reg[CMD_W-1:CMD_W-8];
  assign nn            = cmd_reg[7:0];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: IDLE fetches the FIFO head, EXEC applies it for one cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    exec_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd.cmd_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latch the head word when the FSM pops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cmd_reg <= '0;
    else if (pop)  cmd_reg <= mem[rd_ptr];
  end

  // Decode the latched word into next output values and command class.
  always_comb begin
    ch_d     = ch_enable;
    avg_d    = avg_points;
    led_d    = led;
    is_err   = 1'b0;
    is_clr   = 1'b0;
    is_pulse = 1'b0;
    nn_ok    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (nn == 8'(i)) nn_ok = 1'b1;
    end
    case (opcode)
      8'hF0: ch_d = cmd_reg[N_CH-1:0];
      8'hF1: begin
        for (int i = 0; i < N_CH; i++) begin
          if (nn == 8'(i)) ch_d[i] = 1'b1;
        end
        is_err = !nn_ok;
      end
      8'hF2: begin
        for (int i = 0; i < N_CH; i++) begin
          if (nn == 8'(i)) ch_d[i] = 1'b0;
        end
        is_err = !nn_ok;
      end
      8'hC0: avg_d = cmd_reg[AVG_W-1:0];
      8'hB0: led_d = cmd_reg[LED_W-1:0];
      8'hA0: begin
        if (nn == 8'h00)      is_pulse = 1'b1;
        else if (nn == 8'h01) is_clr   = 1'b1;
        else                  is_err   = 1'b1;
      end
      default: is_err = 1'b1;
    endcase
  end

  // Output and counter update at the EXEC edge; errors only bump err_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_enable  <= '0;
      avg_points <= '0;
      led        <= '1;
      cmd_count  <= '0;
      err_count  <= '0;
    end else if (exec_en) begin
      ch_enable  <= ch_d;
      avg_points <= avg_d;
      led        <= led_d;
      if (is_clr) begin
        cmd_count <= '0;
        err_count <= '0;
      end else if (is_err) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else begin
        cmd_count <= cmd_count + 16'd1;
      end
    end
  end

  // Clear-pulse stretcher; a repeat clear command reloads so pulses merge without a gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  pulse_cnt <= '0;
    else if (exec_en && is_pulse)  pulse_cnt <= PW'(RST_PULSE);
    else if (pulse_cnt != '0)      pulse_cnt <= pulse_cnt - 1'b1;
  end
endmodule

// File: tb/tb_usb_cmd_decoder_multi.sv
// tb/tb_usb_cmd_decoder_multi.sv - scoreboard bench for usb_cmd_decoder_multi
module tb_usb_cmd_decoder_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_cmd_decoder_multi_if #(.CMD_W(16)) bus ();

  logic [3:0]  ch_enable;
  logic [2:0]  avg_points;
  logic [3:0]  led;
  logic        fifo_rst;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;

  usb_cmd_decoder_multi #(
    .CMD_W(16), .N_CH(4), .AVG_W(3), .LED_W(4), .FIFO_DEPTH(8), .RST_PULSE(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (bus),
    .ch_enable  (ch_enable),
    .avg_points (avg_points),
    .led        (led),
    .fifo_rst   (fifo_rst),
    .cmd_count  (cmd_count),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic [3:0]  ch;
    logic [2:0]  avg;
    logic [3:0]  led;
    logic [15:0] cc;
    logic [7:0]  ec;
  } snap_t;

  localparam snap_t RESET_SNAP = '{ch: 4'h0, avg: 3'h0, led: 4'hF, cc: 16'h0, ec: 8'h0};

  snap_t exp_q[$];
  snap_t m = RESET_SNAP;
  int    checks = 0;
  int    errors = 0;
  logic  pending = 1'b0;
  bit    seen_full = 1'b0;
  int    run = 0;
  int    last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_exec(input logic [15:0] c);
    logic err;
    err = 1'b0;
    case (c[15:8])
      8'hF0: m.ch = c[3:0];
      8'hF1: if (c[7:0] < 8'd4) m.ch[c[1:0]] = 1'b1; else err = 1'b1;
      8'hF2: if (c[7:0] < 8'd4) m.ch[c[1:0]] = 1'b0; else err = 1'b1;
      8'hC0: m.avg = c[2:0];
      8'hB0: m.led = c[3:0];
      8'hA0: if (c[7:0] > 8'd1) err = 1'b1;
      default: err = 1'b1;
    endcase
    if (c == 16'hA001) begin
      m.cc = 16'h0;
      m.ec = 8'h0;
    end else if (err) begin
      if (m.ec != 8'hFF) m.ec = m.ec + 8'd1;
    end else begin
      m.cc = m.cc + 16'd1;
    end
  endtask

  task automatic send(input logic [15:0] c);
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    while (!bus.cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
      bus.cmd_valid = 1'b0;
      return;
    end
    model_exec(c);
    exp_q.push_back(m);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ch"},    32'(ch_enable),     32'h0);
    check({tag, "_avg"},   32'(avg_points),    32'h0);
    check({tag, "_led"},   32'(led),           32'hF);
    check({tag, "_rst"},   32'(fifo_rst),      32'h0);
    check({tag, "_cc"},    32'(cmd_count),     32'h0);
    check({tag, "_ec"},    32'(err_count),     32'h0);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'h1);
  endtask

  // Scoreboard monitor: each executed command is compared against the queued expectation.
  always @(negedge clk) begin
    snap_t e;
    snap_t a;
    if (!reset_n) begin
      pending = 1'b0;
      run = 0;
    end else begin
      if (pending) begin
        a = '{ch: ch_enable, avg: avg_points, led: led, cc: cmd_count, ec: err_count};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_exec actual=%0h required=no_exec", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL exec_state actual=%0h required=%0h", a, e);
          end
        end
      end
      pending = dut.exec_en;
      if (!bus.cmd_ready) seen_full = 1'b1;
      if (fifo_rst) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] burst [16];
    burst = '{16'hF001, 16'hC001, 16'hB001, 16'hF002, 16'hC002, 16'hB002, 16'hF003, 16'hC003,
              16'hB003, 16'hF008, 16'hC004, 16'hB00C, 16'hF00F, 16'hC007, 16'hB005, 16'hF106};
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single write with latency check: update lands two edges after acceptance.
    send(16'hF005);
    check("lat_t0_ch", 32'(ch_enable), 32'h0);
    @(negedge clk);
    check("lat_t1_ch", 32'(ch_enable), 32'h0);
    @(negedge clk);
    check("lat_t2_ch", 32'(ch_enable), 32'h5);
    check("lat_t2_cc", 32'(cmd_count), 32'h1);

    // Per-channel set/clear and an out-of-range channel.
    send(16'hF103);
    drain();
    check("set3_ch", 32'(ch_enable), 32'hD);
    send(16'hF200);
    drain();
    check("clr0_ch", 32'(ch_enable), 32'hC);
    send(16'hF104);
    drain();
    check("bad_ch", 32'(ch_enable), 32'hC);
    check("bad_ec", 32'(err_count), 32'h1);
    check("bad_cc", 32'(cmd_count), 32'h3);

    // Two clears two cycles apart merge into one 6-cycle pulse.
    last_run = 0;
    send(16'hA000);
    @(negedge clk);
    send(16'hA000);
    repeat (10) @(negedge clk);
    drain();
    check("pulse_len", 32'(last_run), 32'd6);

    // Reset, then a back-to-back burst deep enough to fill the FIFO.
    @(negedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    m = RESET_SNAP;
    @(negedge clk);
    #1 reset_n = 1'b1;
    seen_full = 1'b0;
    for (int i = 0; i < 16; i++) send(burst[i]);
    drain();
    check("burst_full_seen", 32'(seen_full), 32'h1);
    check("burst_cc", 32'(cmd_count), 32'd15);
    check("burst_ec", 32'(err_count), 32'd1);
    check("burst_ch", 32'(ch_enable), 32'hF);
    check("burst_avg", 32'(avg_points), 32'h7);
    check("burst_led", 32'(led), 32'h5);

    // Error counter saturation, counter clear, then LED write.
    for (int i = 0; i < 300; i++) send(16'h1234);
    drain();
    check("sat_ec", 32'(err_count), 32'd255);
    check("sat_cc", 32'(cmd_count), 32'd15);
    send(16'hA001);
    drain();
    check("clr_ec", 32'(err_count), 32'd0);
    check("clr_cc", 32'(cmd_count), 32'd0);
    send(16'hB00A);
    drain();
    check("led_a", 32'(led), 32'hA);
    check("led_cc", 32'(cmd_count), 32'd1);

    // Reset asserted mid-burst and mid-pulse acts at once and discards queued words.
    send(16'hA000);
    send(16'hF001);
    send(16'hF002);
    send(16'hF003);
    send(16'hF004);
    send(16'hF005);
    check("pre_rst_pulse", 32'(fifo_rst), 32'h1);
    #1 reset_n = 1'b0;
    exp_q.delete();
    m = RESET_SNAP;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_ch", 32'(ch_enable), 32'h0);
    check("post_rst_cc", 32'(cmd_count), 32'h0);
    send(16'hF00F);
    drain();
    check("post_rst_f00f_ch", 32'(ch_enable), 32'hF);
    check("post_rst_f00f_cc", 32'(cmd_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
